// File: rtl/sarray_grid.sv
// sarray_grid: output-stationary systolic matrix-multiply array.
// C[ROWS][COLS] = A*B (optionally added to the previous C). A columns and
// B rows are streamed in K beats, skewed internally, and the result is
// drained one row per handshake.
// Optional build macro: SARRAY_GRID_SAT_EN -- saturating accumulation
// (default: two's-complement wrap).
module sarray_grid #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DW   = 8,
   parameter int AW   = 32,
   parameter int KW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [KW-1:0]        k_len_i,
   input  logic                 acc_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [ROWS*DW-1:0]   a_data_i,
   input  logic [COLS*DW-1:0]   b_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [COLS*AW-1:0]   out_data_o,
   output logic                 out_last_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FW = $clog2(ROWS + COLS);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);

`ifdef SARRAY_GRID_SAT_EN
   function automatic logic signed [AW-1:0] sat_fn(input logic signed [AW:0] s);
      if (s[AW] != s[AW-1])
         return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      return s[AW-1:0];
   endfunction
`endif

   function automatic logic signed [AW-1:0] mac_fn(input logic signed [AW-1:0] acc,
                                                   input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
      logic signed [2*DW-1:0] prod;
      logic signed [AW:0]     sum;
      prod = (2*DW)'(a) * (2*DW)'(b);
      sum  = (AW+1)'(acc) + (AW+1)'(prod);
`ifdef SARRAY_GRID_SAT_EN
      return sat_fn(sum);
`else
      return sum[AW-1:0];
`endif
   endfunction

   state_t          state_q, state_d;
   logic [KW-1:0]   k_len_q, k_cnt_q;
   logic [FW-1:0]   flush_cnt_q;
   logic [RW-1:0]   row_cnt_q;
   logic            done_q;
   logic            beat, clr;

   logic signed [DW-1:0] a_src [ROWS];
   logic signed [DW-1:0] b_src [COLS];
   logic signed [DW-1:0] a_sk  [ROWS][ROWS];
   logic                 av_sk [ROWS][ROWS];
   logic signed [DW-1:0] b_sk  [COLS][COLS];
   logic                 bv_sk [COLS][COLS];
   logic signed [DW-1:0] a_in  [ROWS][COLS];
   logic                 av_in [ROWS][COLS];
   logic signed [DW-1:0] b_in  [ROWS][COLS];
   logic                 bv_in [ROWS][COLS];
   logic signed [DW-1:0] a_pe  [ROWS][COLS];
   logic                 av_pe [ROWS][COLS];
   logic signed [DW-1:0] b_pe  [ROWS][COLS];
   logic                 bv_pe [ROWS][COLS];
   logic signed [AW-1:0] acc_q [ROWS][COLS];

   assign beat   = in_valid_i && (state_q == LOAD);
   assign done_o = done_q;

   // Next-state decode and control outputs.
   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
      busy_o      = 1'b1;
      clr         = 1'b0;
      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               clr     = !acc_i;
               state_d = (k_len_i == '0) ? DRAIN : LOAD;
            end
         end
         LOAD: begin
            in_ready_o = 1'b1;
            if (in_valid_i && (k_cnt_q == k_len_q - KW'(1)))
               state_d = FLUSH;
         end
         FLUSH: begin
            if (flush_cnt_q == '0)
               state_d = DRAIN;
         end
         DRAIN: begin
            out_valid_o = 1'b1;
            out_last_o  = (row_cnt_q == RW'(ROWS - 1));
            if (out_ready_i && out_last_o)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Beat, flush and row counters plus the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_len_q     <= '0;
         k_cnt_q     <= '0;
         flush_cnt_q <= '0;
         row_cnt_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  k_len_q   <= k_len_i;
                  k_cnt_q   <= '0;
                  row_cnt_q <= '0;
               end
            end
            LOAD: begin
               flush_cnt_q <= FLUSH_LAST;
               if (beat) k_cnt_q <= k_cnt_q + KW'(1);
            end
            FLUSH: begin
               flush_cnt_q <= flush_cnt_q - FW'(1);
               row_cnt_q   <= '0;
            end
            DRAIN: begin
               if (out_ready_i) begin
                  if (out_last_o) begin
                     row_cnt_q <= '0;
                     done_q    <= 1'b1;
                  end else begin
                     row_cnt_q <= row_cnt_q + RW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Unpack operand lanes.
   always_comb begin
      for (int r = 0; r < ROWS; r++) a_src[r] = a_data_i[r*DW +: DW];
      for (int c = 0; c < COLS; c++) b_src[c] = b_data_i[c*DW +: DW];
   end

   // Skew stage: row r / column c delayed by r / c registers (valid tags).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < ROWS; j++) av_sk[r][j] <= 1'b0;
         for (int c = 0; c < COLS; c++)
            for (int j = 0; j < COLS; j++) bv_sk[c][j] <= 1'b0;
      end else begin
         for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < ROWS; j++)
               if (j < r) av_sk[r][j] <= (j == 0) ? beat : av_sk[r][(j > 0) ? j-1 : 0];
         for (int c = 0; c < COLS; c++)
            for (int j = 0; j < COLS; j++)
               if (j < c) bv_sk[c][j] <= (j == 0) ? beat : bv_sk[c][(j > 0) ? j-1 : 0];
      end
   end

   // Skew stage: operand data.
   always_ff @(posedge clk) begin
      for (int r = 0; r < ROWS; r++)
         for (int j = 0; j < ROWS; j++)
            if (j < r) a_sk[r][j] <= (j == 0) ? a_src[r] : a_sk[r][(j > 0) ? j-1 : 0];
      for (int c = 0; c < COLS; c++)
         for (int j = 0; j < COLS; j++)
            if (j < c) b_sk[c][j] <= (j == 0) ? b_src[c] : b_sk[c][(j > 0) ? j-1 : 0];
   end

   // PE operand routing: edge PEs take skewed inputs, inner PEs their neighbour.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (c == 0) begin
               a_in[r][c]  = (r == 0) ? a_src[r] : a_sk[r][(r > 0) ? r-1 : 0];
               av_in[r][c] = (r == 0) ? beat     : av_sk[r][(r > 0) ? r-1 : 0];
            end else begin
               a_in[r][c]  = a_pe[r][(c > 0) ? c-1 : 0];
               av_in[r][c] = av_pe[r][(c > 0) ? c-1 : 0];
            end
            if (r == 0) begin
               b_in[r][c]  = (c == 0) ? b_src[c] : b_sk[c][(c > 0) ? c-1 : 0];
               bv_in[r][c] = (c == 0) ? beat     : bv_sk[c][(c > 0) ? c-1 : 0];
            end else begin
               b_in[r][c]  = b_pe[(r > 0) ? r-1 : 0][c];
               bv_in[r][c] = bv_pe[(r > 0) ? r-1 : 0][c];
            end
         end
      end
   end

   // PE stage: forward valid tags and accumulate when both operands are valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               av_pe[r][c] <= 1'b0;
               bv_pe[r][c] <= 1'b0;
               acc_q[r][c] <= '0;
            end
      end else begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               av_pe[r][c] <= av_in[r][c];
               bv_pe[r][c] <= bv_in[r][c];
               if (clr)
                  acc_q[r][c] <= '0;
               else if (av_in[r][c] && bv_in[r][c])
                  acc_q[r][c] <= mac_fn(acc_q[r][c], a_in[r][c], b_in[r][c]);
            end
      end
   end

   // PE stage: forward operand data right and down.
   always_ff @(posedge clk) begin
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            a_pe[r][c] <= a_in[r][c];
            b_pe[r][c] <= b_in[r][c];
         end
   end

   // Drain mux: accumulator row selected by the row counter.
   always_comb begin
      out_data_o = '0;
      if (state_q == DRAIN)
         for (int c = 0; c < COLS; c++)
            out_data_o[c*AW +: AW] = acc_q[row_cnt_q][c];
   end

endmodule

// File: tb/tb_sarray_grid.sv
// tb_sarray_grid: directed bench for sarray_grid (4x4, DW=8, AW=16).
// Expected rows come from a reference model and are queued when a command
// is issued, then popped as the array drains them.
module tb_sarray_grid;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DW   = 8;
   localparam int AW   = 16;
   localparam int KW   = 16;
   localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
   localparam longint MINV = -(longint'(1) << (AW-1));

   logic                clk = 1'b0;
   logic                rst;
   logic                start_i;
   logic [KW-1:0]       k_len_i;
   logic                acc_i;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [ROWS*DW-1:0]  a_data_i;
   logic [COLS*DW-1:0]  b_data_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [COLS*AW-1:0]  out_data_o;
   logic                out_last_o;
   logic                busy_o;
   logic                done_o;

   int n_tests = 0;
   int n_fail  = 0;

   int     a_mat [16][ROWS];
   int     b_mat [16][COLS];
   longint exp_c [ROWS][COLS];
   logic [COLS*AW-1:0] exp_q [$];

   sarray_grid #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .k_len_i(k_len_i), .acc_i(acc_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .a_data_i(a_data_i), .b_data_i(b_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_tests++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic longint step(input longint acc, input longint p);
      longint s;
      logic signed [AW-1:0] t;
      s = acc + p;
`ifdef SARRAY_GRID_SAT_EN
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
`else
      t = s[AW-1:0];
      s = longint'(t);
`endif
      return s;
   endfunction

   task automatic model_cmd(input int klen, input bit acc);
      logic [COLS*AW-1:0] row;
      if (!acc)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_c[r][c] = 0;
      for (int k = 0; k < klen; k++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               exp_c[r][c] = step(exp_c[r][c], longint'(a_mat[k][r]) * longint'(b_mat[k][c]));
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) row[c*AW +: AW] = exp_c[r][c][AW-1:0];
         exp_q.push_back(row);
      end
   endtask

   task automatic drive_beat(input int k);
      for (int r = 0; r < ROWS; r++) a_data_i[r*DW +: DW] = DW'(a_mat[k][r]);
      for (int c = 0; c < COLS; c++) b_data_i[c*DW +: DW] = DW'(b_mat[k][c]);
   endtask

   task automatic set_identity;
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) a_mat[k][r] = (r == k) ? 1 : 0;
         for (int c = 0; c < COLS; c++) b_mat[k][c] = 10*k + c;
      end
   endtask

   // Issue one command, feed its beats, then drain and score all rows.
   // Returns in the done_o cycle so the next command starts back-to-back.
   task automatic run_cmd(input int klen, input bit acc, input bit gaps,
                          input int stall_row, input int exp_first);
      int cyc, k, bound;
      bit phase;
      logic [COLS*AW-1:0] exp_row, held;
      model_cmd(klen, acc);
      start_i = 1'b1; k_len_i = KW'(klen); acc_i = acc;
      cyc = 0;
      tick; cyc++;
      start_i = 1'b0; k_len_i = '0; acc_i = 1'b0;
      chk("done_low_after_start", done_o, 0);
      chk("busy_after_start", busy_o, 1);
      k = 0; bound = 0; phase = 1'b1;
      while (k < klen && bound < 200) begin
         in_valid_i = gaps ? phase : 1'b1;
         if (in_valid_i) drive_beat(k);
         else begin
            a_data_i = ROWS*DW'($urandom);
            b_data_i = COLS*DW'($urandom);
         end
         chk("in_ready_load", in_ready_o, 1);
         tick; cyc++; bound++;
         if (in_valid_i) k++;
         phase = ~phase;
      end
      in_valid_i = 1'b0;
      bound = 0;
      while (!out_valid_o && bound < 100) begin
         tick; cyc++; bound++;
      end
      chk("out_valid_seen", out_valid_o, 1);
      chk("first_valid_cycle", cyc, exp_first);
      for (int r = 0; r < ROWS; r++) begin
         exp_row = exp_q.pop_front();
         if (r == stall_row) begin
            out_ready_i = 1'b0;
            held = out_data_o;
            for (int s = 0; s < 3; s++) begin
               tick; cyc++;
               chk("stall_data_hold", out_data_o, held);
               chk("stall_valid_hold", out_valid_o, 1);
            end
         end
         out_ready_i = 1'b1;
         chk("row_data", out_data_o, exp_row);
         chk("row_last", out_last_o, (r == ROWS-1));
         chk("done_not_early", done_o, 0);
         tick; cyc++;
      end
      out_ready_i = 1'b0;
      chk("done_pulse", done_o, 1);
      chk("idle_at_done", busy_o, 0);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; k_len_i = '0; acc_i = 1'b0;
      in_valid_i = 1'b0; a_data_i = '0; b_data_i = '0; out_ready_i = 1'b0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_c[r][c] = 0;
      repeat (3) tick;
      rst = 1'b0;
      tick;

      // Reset state.
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_out_data", out_data_o, 0);
      chk("rst_out_last", out_last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);

      // Identity, then the same command accumulated (doubles every element).
      set_identity();
      run_cmd(4, 1'b0, 1'b0, -1, 12);
      run_cmd(4, 1'b1, 1'b0, -1, 12);
      chk("acc_c32", out_data_o, 0);  // out_data_o is zero outside DRAIN
      chk("model_c32_doubled", exp_c[3][2], 64);

      // Bubbles in LOAD, backpressure on row 1.
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < ROWS; r++) a_mat[k][r] = 1;
         for (int c = 0; c < COLS; c++) b_mat[k][c] = 2;
      end
      run_cmd(3, 1'b0, 1'b1, 1, 13);

      // Zero-length command clears a non-zero result.
      run_cmd(0, 1'b0, 1'b0, -1, 1);

      // Signed random operands, then accumulate a second random product.
      for (int k = 0; k < 5; k++) begin
         for (int r = 0; r < ROWS; r++) a_mat[k][r] = int'($urandom_range(0, 255)) - 128;
         for (int c = 0; c < COLS; c++) b_mat[k][c] = int'($urandom_range(0, 255)) - 128;
      end
      run_cmd(5, 1'b0, 1'b0, -1, 13);
      run_cmd(3, 1'b1, 1'b0, 2, 11);

      // Saturation / wrap corner.
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < ROWS; r++) a_mat[k][r] = 127;
         for (int c = 0; c < COLS; c++) b_mat[k][c] = 127;
      end
      run_cmd(3, 1'b0, 1'b0, -1, 11);
`ifdef SARRAY_GRID_SAT_EN
      chk("sat_model", exp_c[1][1], 64'(32767));
`else
      chk("wrap_model", exp_c[1][1], 64'(-17149));
`endif

      // Reset in the middle of LOAD aborts the command.
      tick;
      set_identity();
      start_i = 1'b1; k_len_i = KW'(8); acc_i = 1'b0;
      tick;
      start_i = 1'b0; k_len_i = '0;
      for (int k = 0; k < 4; k++) begin
         in_valid_i = 1'b1;
         drive_beat(k);
         tick;
      end
      in_valid_i = 1'b1;
      rst = 1'b1;
      #1;
      chk("abort_in_ready", in_ready_o, 0);
      chk("abort_out_valid", out_valid_o, 0);
      chk("abort_out_data", out_data_o, 0);
      chk("abort_out_last", out_last_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_done", done_o, 0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid_i = 1'b0;
      tick;
      chk("abort_no_done", done_o, 0);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_c[r][c] = 0;
      run_cmd(4, 1'b1, 1'b0, -1, 12);

      tick;
      chk("done_single_pulse", done_o, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sarray_grid.md
# sarray_grid

Parametrised output-stationary systolic matrix-multiply array with internal operand skew, a start/done command interface and a handshaked, row-by-row result drain. It is the next-generation array for the tensor datapath. The operand loader streams K beats of A columns and B rows into it. The array computes C[ROWS][COLS] = A·B, optionally added to the previous C. The store path then reads C one row per beat.

## Interface
- ROWS, 4: PE rows (M dimension), ≥2
- COLS, 4: PE columns (N dimension), ≥2
- DW, 8: signed operand width
- AW, 32: signed accumulator width, ≥2·DW
- KW, 16: width of the K-length field
- One clock `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  async active-high reset
- start_i  in  1  command strobe, honoured only in IDLE
- k_len_i  in  KW  K beats for this command, sampled with start_i
- acc_i  in  1  1 = add to existing C, 0 = clear C first; sampled with start_i
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  operand beat accepted when in_valid_i & in_ready_o
- a_data_i  in  ROWS·DW  A column k; row r at [r·DW +: DW]
- b_data_i  in  COLS·DW  B row k; column c at [c·DW +: DW]
- out_valid_o  out  1  result row valid
- out_ready_i  in  1  result row consumed when out_valid_o & out_ready_i
- out_data_o  out  COLS·AW  C row; column c at [c·AW +: AW]
- out_last_o  out  1  current row is row ROWS-1
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse after the last row handshake

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE → LOAD on start_i. If k_len_i = 0, IDLE → DRAIN directly.
- On start_i with acc_i = 0, all accumulators clear in that same cycle.
- LOAD: in_ready_o = 1. The block counts accepted beats. After beat k_len_i-1 is accepted, LOAD → FLUSH.
- A cycle with no handshake in LOAD injects a bubble (valid tag 0). The array never stalls.
- Skew: row r of A passes through r registers before entering PE(r,0). Column c of B passes through c registers before entering PE(0,c).
- Each PE registers its A operand to the right and its B operand downward, each with a valid tag.
- A PE accumulates only when both incoming tags are 1: acc += sext(a·b), signed.
- FLUSH lasts exactly ROWS+COLS-1 cycles (down-counter), then FLUSH → DRAIN.
- DRAIN: the row counter starts at 0. out_data_o is the accumulator row selected by the counter. out_valid_o = 1.
- On each handshake the row counter increments. out_data_o, out_valid_o and out_last_o hold stable while out_ready_i = 0.
- After the handshake with out_last_o = 1: DRAIN → IDLE, done_o = 1 for one cycle.
- Accumulators keep their value in IDLE. This allows a following command with acc_i = 1 to accumulate onto them.
- start_i outside IDLE is ignored.
- in_valid_i outside LOAD is ignored; in_ready_o = 0 outside LOAD.

## Timing
- Reset values: in_ready_o = 0, out_valid_o = 0, out_data_o = 0, out_last_o = 0, busy_o = 0, done_o = 0.
- Reset also forces state IDLE, zeroes all accumulators and clears all skew and PE valid tags.
- Reset mid-command aborts the command. No done_o is produced.
- Cycle numbering: start_i high at cycle 0; LOAD from cycle 1.
- in_ready_o is high from cycle 1. With back-to-back beats, the last beat is accepted at cycle k_len.
- Beat k reaches PE(r,c) r+c cycles after acceptance and is accumulated on the following edge.
- First out_valid_o: cycle k_len + ROWS + COLS, for unstalled input.
- With k_len = 0, out_valid_o first appears at cycle 1.
- Minimum command duration, start to done_o, with out_ready_i held high: k_len + ROWS + COLS + ROWS cycles.
- done_o is asserted the cycle after the last handshake. IDLE accepts a new start_i in that same cycle.

## Configuration
- Macro SARRAY_GRID_SAT_EN.
  - Defined: each accumulate saturates to the signed AW range [-2^(AW-1), 2^(AW-1)-1].
  - Undefined: accumulation wraps modulo 2^AW (two's complement).

## Test plan
- Identity: ROWS = COLS = 4, k_len = 4, A = I, B[k][c] = 10k+c, acc_i = 0 → rows out = B rows. First out_valid_o at cycle 12. done_o one cycle after row 3.
- Accumulate: run the identity command, then repeat it with acc_i = 1 → every C element is doubled (e.g. C[3][2] = 64).
- Bubbles and backpressure:
  - In LOAD, in_valid_i toggles 1,0,1,0…; A = all 1, B = all 2, k_len = 3 → all C = 6.
  - In DRAIN, out_ready_i is low for 3 cycles on row 1 → out_data_o stays stable for those cycles and no row is dropped.
- k_len = 0 with acc_i = 0 after a non-zero result → 4 all-zero rows, then done_o.
- Saturation, AW = 16, DW = 8, A = B = 127, k_len = 3:
  - SARRAY_GRID_SAT_EN defined → C = 32767.
  - Macro undefined → C = 48387 mod 65536, i.e. -17149.
- Reset asserted at cycle 5 of LOAD → all outputs 0 immediately. A subsequent acc_i = 1 command yields results from a zero base.
